// File: rtl/cpu_pkg.sv
// Shared CPU definitions: the fetch slot record, the canonical NOP encoding and the default
// fetch-buffer depth.
package cpu_pkg;

    localparam int unsigned IFETCH_DEPTH = 2;
    localparam int unsigned PC_MAX_W     = 32;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    typedef struct packed {
        logic [PC_MAX_W-1:0] pc;
        logic [31:0]         instr;
        logic                filled;
    } fetch_slot_t;

endpackage

// File: rtl/ifetch_buffer.sv
// Instruction-fetch buffer: issues PCs to imem, pairs in-order responses with their PCs and queues them for decode.
// Define IFETCH_PERF_EN to add saturating bubble/drop performance counters.
module ifetch_buffer
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = IFETCH_DEPTH
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic [WIDTH-1:0] pc_in,
    output logic             pc_stall,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    input  logic             flush,
    input  logic             id_ready,
    output logic             id_valid,
    output logic [31:0]      id_instr,
    output logic [WIDTH-1:0] id_pc
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]      perf_bubble,
    output logic [31:0]      perf_drop
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_slot_t      slots [DEPTH];
    logic [PTR_W-1:0] alloc_ptr, fill_ptr, rd_ptr;
    logic [CNT_W-1:0] count, pending, drop_cnt, inflight;
    logic             grant, accept, pop, discard;

    // pending tracks granted-but-unanswered slots; together with drop_cnt it is everything still in flight
    assign inflight  = pending + drop_cnt;
    assign imem_req  = nReset && !flush && (count < CNT_W'(DEPTH)) && (drop_cnt == '0);
    assign imem_addr = pc_in;
    assign grant     = imem_req && imem_gnt;
    assign pc_stall  = !grant && !flush;
    assign accept    = imem_rvalid && !flush && (drop_cnt == '0) && (pending != '0);
    assign discard   = imem_rvalid && (flush || drop_cnt != '0) && (inflight != '0);
    assign id_valid  = slots[rd_ptr].filled && (count != '0);
    assign id_instr  = slots[rd_ptr].instr;
    assign id_pc     = slots[rd_ptr].pc[WIDTH-1:0];
    assign pop       = id_valid && id_ready && !flush;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            for (int unsigned i = 0; i < DEPTH; i++) slots[i] <= '0;
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pending   <= '0;
            drop_cnt  <= '0;
        end else if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) slots[i] <= '0;
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pending   <= '0;
            // earlier drops still owed carry over; a response arriving now is itself discarded
            drop_cnt  <= inflight - CNT_W'(imem_rvalid && (inflight != '0));
        end else begin
            if (grant) begin
                slots[alloc_ptr].pc     <= PC_MAX_W'(pc_in);
                slots[alloc_ptr].instr  <= '0;
                slots[alloc_ptr].filled <= 1'b0;
                alloc_ptr               <= alloc_ptr + 1'b1;
            end
            if (accept) begin
                slots[fill_ptr].instr  <= imem_rdata;
                slots[fill_ptr].filled <= 1'b1;
                fill_ptr               <= fill_ptr + 1'b1;
            end
            if (pop) begin
                slots[rd_ptr].filled <= 1'b0;
                rd_ptr               <= rd_ptr + 1'b1;
            end
            if (grant && !pop)      count <= count + 1'b1;
            else if (!grant && pop) count <= count - 1'b1;
            if (grant && !accept)      pending <= pending + 1'b1;
            else if (!grant && accept) pending <= pending - 1'b1;
            if (imem_rvalid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
        end
    end

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            perf_bubble <= '0;
            perf_drop   <= '0;
        end else begin
            if (id_ready && !id_valid && perf_bubble != '1) perf_bubble <= perf_bubble + 1'b1;
            if (discard && perf_drop != '1)                 perf_drop   <= perf_drop + 1'b1;
        end
    end
`else
    logic unused_discard;
    assign unused_discard = discard;
`endif

endmodule

// File: tb/tb_ifetch_buffer.sv
// Self-checking bench for ifetch_buffer: fixed vector table, directed flush/reset sequences and a
// randomized run against a queue-based reference model.
module tb_ifetch_buffer;

    localparam int unsigned W = 32;
    localparam int unsigned D = 2;

    logic          clk = 1'b0;
    logic          nReset;
    logic [W-1:0]  pc_in;
    logic          pc_stall, imem_req, imem_gnt, imem_rvalid, flush, id_ready, id_valid;
    logic [W-1:0]  imem_addr, id_pc;
    logic [31:0]   imem_rdata, id_instr;
`ifdef IFETCH_PERF_EN
    logic [31:0]   perf_bubble, perf_drop;
`endif

    ifetch_buffer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .nReset(nReset), .pc_in(pc_in), .pc_stall(pc_stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .flush(flush),
        .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc)
`ifdef IFETCH_PERF_EN
        , .perf_bubble(perf_bubble), .perf_drop(perf_drop)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: an ordered list of fetches awaiting decode plus a count of responses owed to a flush.
    typedef struct { logic [31:0] pc; logic [31:0] instr; bit filled; } ent_t;
    ent_t          q[$];
    int            m_drop;
    logic [31:0]   pc_reg;
    logic [31:0]   tgt;
    logic [31:0]   popped[$];
    bit            m_req, m_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_pending();
        int n = 0;
        foreach (q[i]) if (!q[i].filled) n++;
        return n;
    endfunction

    function automatic int outstanding();
        return m_pending() + m_drop;
    endfunction

    // Drive one cycle's inputs (called just after a negedge) and compare against the model.
    task automatic apply(input bit fl, input logic [31:0] target, input bit gnt, input bit rv,
                         input logic [31:0] rd, input bit rdy);
        flush = fl; tgt = target; imem_gnt = gnt; imem_rvalid = rv; imem_rdata = rd; id_ready = rdy;
        pc_in = pc_reg;
        #1;
        m_req   = !fl && (q.size() < D) && (m_drop == 0);
        m_valid = (q.size() > 0) && q[0].filled;
        check("req",   {31'd0, imem_req}, {31'd0, m_req});
        check("stall", {31'd0, pc_stall}, {31'd0, !(m_req && gnt) && !fl});
        check("addr",  imem_addr, pc_reg);
        check("valid", {31'd0, id_valid}, {31'd0, m_valid});
        if (m_valid) begin
            check("id_pc",    id_pc,    q[0].pc);
            check("id_instr", id_instr, q[0].instr);
        end
    endtask

    // Clock edge: advance the model with the inputs applied in this cycle.
    task automatic advance();
        bit do_pop;
        int pend;
        @(posedge clk);
        do_pop = m_valid && id_ready && !flush;
        pend   = m_pending();
        if (flush) begin
            m_drop = m_drop + pend - ((imem_rvalid && (m_drop + pend) > 0) ? 1 : 0);
            q.delete();
            pc_reg = tgt;
        end else begin
            if (imem_rvalid && m_drop > 0) m_drop--;
            else if (imem_rvalid) begin
                for (int i = 0; i < q.size(); i++)
                    if (!q[i].filled) begin q[i].instr = imem_rdata; q[i].filled = 1; break; end
            end
            if (do_pop) begin popped.push_back(q[0].pc); void'(q.pop_front()); end
            if (m_req && imem_gnt) begin
                q.push_back('{pc: pc_reg, instr: 32'd0, filled: 1'b0});
                pc_reg = pc_reg + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic step(input bit fl, input logic [31:0] target, input bit gnt, input bit rv,
                        input logic [31:0] rd, input bit rdy);
        apply(fl, target, gnt, rv, rd, rdy);
        advance();
    endtask

    typedef struct {
        bit fl; logic [31:0] target; bit gnt; bit rv; logic [31:0] rd; bit rdy;
        bit e_req; bit e_stall; bit e_valid; logic [31:0] e_pc; logic [31:0] e_instr;
    } vec_t;
    vec_t vecs[10];

    initial begin
        nReset = 1'b0; pc_in = '0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
        flush = 0; id_ready = 0; tgt = '0;
        pc_reg = 32'd0; m_drop = 0; q.delete();

        // Reset state while nReset is low.
        @(negedge clk); #1;
        check("rst_req",   {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, id_valid}, 32'd0);
        check("rst_pc",    id_pc,    32'd0);
        check("rst_instr", id_instr, 32'd0);
        @(negedge clk);
        nReset = 1'b1;

        //          fl target     gnt rv rd            rdy  req stall valid pc           instr
        vecs[0] = '{0, 32'h0,     1,  0, 32'h0,        0,   1,  0,    0,    32'h0,       32'h0};
        vecs[1] = '{0, 32'h0,     0,  1, 32'hAAAA0001, 0,   1,  1,    0,    32'h0,       32'h0};
        vecs[2] = '{0, 32'h0,     0,  0, 32'h0,        0,   1,  1,    1,    32'h0,       32'hAAAA0001};
        vecs[3] = '{0, 32'h0,     1,  0, 32'h0,        0,   1,  0,    1,    32'h0,       32'hAAAA0001};
        vecs[4] = '{0, 32'h0,     1,  0, 32'h0,        0,   0,  1,    1,    32'h0,       32'hAAAA0001};
        vecs[5] = '{0, 32'h0,     1,  1, 32'hBBBB0002, 1,   0,  1,    1,    32'h0,       32'hAAAA0001};
        vecs[6] = '{0, 32'h0,     0,  0, 32'h0,        1,   1,  1,    1,    32'h4,       32'hBBBB0002};
        vecs[7] = '{0, 32'h0,     0,  0, 32'h0,        1,   1,  1,    0,    32'h0,       32'h0};
        vecs[8] = '{1, 32'h100,   1,  0, 32'h0,        0,   0,  0,    0,    32'h0,       32'h0};
        vecs[9] = '{0, 32'h0,     1,  0, 32'h0,        0,   1,  0,    0,    32'h0,       32'h0};
        for (int i = 0; i < 10; i++) begin
            apply(vecs[i].fl, vecs[i].target, vecs[i].gnt, vecs[i].rv, vecs[i].rd, vecs[i].rdy);
            check($sformatf("vec%0d_req", i),   {31'd0, imem_req}, {31'd0, vecs[i].e_req});
            check($sformatf("vec%0d_stall", i), {31'd0, pc_stall}, {31'd0, vecs[i].e_stall});
            check($sformatf("vec%0d_valid", i), {31'd0, id_valid}, {31'd0, vecs[i].e_valid});
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d_pc", i),    id_pc,    vecs[i].e_pc);
                check($sformatf("vec%0d_instr", i), id_instr, vecs[i].e_instr);
            end
            advance();
        end

        // Flush with two responses outstanding: both dropped, no requests until the second drop.
        step(0, 0, 1, 0, 0, 1);
        step(1, 32'h300, 0, 0, 0, 1);
        apply(0, 0, 1, 1, 32'hDEAD0001, 1);
        check("drop2_req_a", {31'd0, imem_req}, 32'd0);
        advance();
        step(0, 0, 1, 0, 0, 1);
        apply(0, 0, 1, 1, 32'hDEAD0002, 1);
        check("drop2_req_b", {31'd0, imem_req}, 32'd0);
        advance();
        apply(0, 0, 1, 0, 0, 1);
        check("resume_req",  {31'd0, imem_req}, 32'd1);
        check("resume_addr", imem_addr, 32'h300);
        advance();

        // Flush coincident with a response and one other outstanding: only the next response dropped.
        step(0, 0, 1, 0, 0, 1);
        step(1, 32'h400, 0, 1, 32'hDEAD0003, 1);
        step(0, 0, 1, 1, 32'hDEAD0004, 1);
        apply(0, 0, 1, 0, 0, 1);
        check("flush_rv_req",  {31'd0, imem_req}, 32'd1);
        check("flush_rv_addr", imem_addr, 32'h400);
        advance();

        // Continuous stream after a redirect: ten instructions must arrive in PC order.
        step(1, 32'h200, 0, (outstanding() > 0), 0, 1);
        popped.delete();
        for (int n = 0; n < 60 && popped.size() < 10; n++)
            step(0, 0, 1, (outstanding() > 0), $urandom, 1);
        check("stream_len", popped.size(), 32'd10);
        for (int i = 0; i < 10 && i < popped.size(); i++)
            check($sformatf("stream_pc%0d", i), popped[i], 32'h200 + 32'(4 * i));

        // Reset mid-burst with filled slots, then a stray late response after release.
        step(0, 0, 1, (outstanding() > 0), 32'h1111_0000, 0);
        step(0, 0, 1, (outstanding() > 0), 32'h1111_0001, 0);
        step(0, 0, 0, (outstanding() > 0), 32'h1111_0002, 0);
        nReset = 1'b0;
        #1;
        check("midrst_valid", {31'd0, id_valid}, 32'd0);
        check("midrst_req",   {31'd0, imem_req}, 32'd0);
        q.delete(); m_drop = 0; pc_reg = 32'd0;
        @(negedge clk);
        nReset = 1'b1;
        step(0, 0, 0, 1, 32'hBAD0_0BAD, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 32'h5555_AAAA, 0);
        apply(0, 0, 0, 0, 0, 0);
        check("post_rst_valid", {31'd0, id_valid}, 32'd1);
        check("post_rst_instr", id_instr, 32'h5555_AAAA);
        check("post_rst_pc",    id_pc,    32'h0);
        advance();

        // Randomized traffic obeying the memory protocol.
        for (int n = 0; n < 3000; n++) begin
            bit fl, gnt, rv, rdy;
            fl  = ($urandom_range(0, 19) == 0);
            gnt = $urandom_range(0, 1);
            rv  = (outstanding() > 0) && ($urandom_range(0, 9) < 6);
            rdy = ($urandom_range(0, 9) < 6);
            step(fl, {$urandom_range(0, 32'hFFFF), 2'b00}, gnt, rv, $urandom, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
